// File: rtl/regfile_scoreboard_if.sv
// regfile_scoreboard_if: decode-stage operand, writeback and claim signals of the register file.
interface regfile_scoreboard_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
);
    logic [ADDR_W-1:0] rs_addr;
    logic [ADDR_W-1:0] rt_addr;
    logic              use_rs;
    logic              use_rt;
    logic [DATA_W-1:0] read_data_1;
    logic [DATA_W-1:0] read_data_2;
    logic              reg_write_en;
    logic [ADDR_W-1:0] write_addr;
    logic [DATA_W-1:0] write_data;
    logic              claim_en;
    logic [ADDR_W-1:0] claim_addr;
    logic              busy_1;
    logic              busy_2;
    logic              stall;
    logic [1:0]        cmp_mode;
    logic              cmp_true;

    modport master (
        output rs_addr, rt_addr, use_rs, use_rt, reg_write_en, write_addr, write_data,
               claim_en, claim_addr, cmp_mode,
        input  read_data_1, read_data_2, busy_1, busy_2, stall, cmp_true
    );

    modport slave (
        input  rs_addr, rt_addr, use_rs, use_rt, reg_write_en, write_addr, write_data,
               claim_en, claim_addr, cmp_mode,
        output read_data_1, read_data_2, busy_1, busy_2, stall, cmp_true
    );
endinterface

// File: rtl/regfile_scoreboard.sv
// regfile_scoreboard: register file with write bypass, pending-write scoreboard,
// hazard stall and branch comparator on the bypassed operands.
module regfile_scoreboard #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter bit ZERO_REG = 1'b1,
    parameter bit BYPASS   = 1'b1
) (
    input logic                 clk,
    input logic                 reset_n,
    regfile_scoreboard_if.slave bus
);
    localparam int DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0] regs [DEPTH];
    logic [DEPTH-1:0]  pending;
    logic              wr_ok, cl_ok;
    logic              zero_1, zero_2, hit_1, hit_2;

    assign wr_ok  = bus.reg_write_en && !(ZERO_REG && bus.write_addr == '0);
    assign cl_ok  = bus.claim_en && !(ZERO_REG && bus.claim_addr == '0);
    assign zero_1 = ZERO_REG && bus.rs_addr == '0;
    assign zero_2 = ZERO_REG && bus.rt_addr == '0;
    assign hit_1  = BYPASS && bus.reg_write_en && bus.write_addr == bus.rs_addr;
    assign hit_2  = BYPASS && bus.reg_write_en && bus.write_addr == bus.rt_addr;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) regs[i] <= '0;
            pending <= '0;
        end else begin
            if (wr_ok) regs[bus.write_addr] <= bus.write_data;
            if (wr_ok) pending[bus.write_addr] <= 1'b0;
            // claim is applied last so a newer producer keeps ownership
            if (cl_ok) pending[bus.claim_addr] <= 1'b1;
        end
    end

    always_comb begin
        bus.read_data_1 = zero_1 ? '0 : hit_1 ? bus.write_data : regs[bus.rs_addr];
        bus.read_data_2 = zero_2 ? '0 : hit_2 ? bus.write_data : regs[bus.rt_addr];
        bus.busy_1      = !zero_1 && pending[bus.rs_addr] && !hit_1;
        bus.busy_2      = !zero_2 && pending[bus.rt_addr] && !hit_2;
        bus.stall       = (bus.busy_1 && bus.use_rs) || (bus.busy_2 && bus.use_rt);
        bus.cmp_true    = bus.cmp_mode == 2'b00 ? bus.read_data_1 == bus.read_data_2 :
                          bus.cmp_mode == 2'b01 ? bus.read_data_1 != bus.read_data_2 :
                          bus.cmp_mode == 2'b10 ? bus.read_data_1[DATA_W-1] :
                                                  !bus.read_data_1[DATA_W-1];
    end
endmodule

// File: tb/tb_regfile_scoreboard.sv
// tb_regfile_scoreboard: directed vectors on a bypassing and a non-bypassing instance sharing stimulus.
module tb_regfile_scoreboard;
    logic clk;
    logic reset_n;
    int   checks = 0;
    int   errors = 0;

    regfile_scoreboard_if #(.DATA_W(32), .ADDR_W(5)) bus ();
    regfile_scoreboard_if #(.DATA_W(32), .ADDR_W(5)) bus_n ();

    assign bus_n.rs_addr      = bus.rs_addr;
    assign bus_n.rt_addr      = bus.rt_addr;
    assign bus_n.use_rs       = bus.use_rs;
    assign bus_n.use_rt       = bus.use_rt;
    assign bus_n.reg_write_en = bus.reg_write_en;
    assign bus_n.write_addr   = bus.write_addr;
    assign bus_n.write_data   = bus.write_data;
    assign bus_n.claim_en     = bus.claim_en;
    assign bus_n.claim_addr   = bus.claim_addr;
    assign bus_n.cmp_mode     = bus.cmp_mode;

    regfile_scoreboard #(.DATA_W(32), .ADDR_W(5), .ZERO_REG(1'b1), .BYPASS(1'b1)) dut (
        .clk(clk), .reset_n(reset_n), .bus(bus.slave));
    regfile_scoreboard #(.DATA_W(32), .ADDR_W(5), .ZERO_REG(1'b1), .BYPASS(1'b0)) dut_n (
        .clk(clk), .reset_n(reset_n), .bus(bus_n.slave));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.reg_write_en = 1'b0;
        bus.claim_en     = 1'b0;
    endtask

    task automatic wr(input logic [4:0] a, input logic [31:0] d);
        bus.reg_write_en = 1'b1;
        bus.write_addr   = a;
        bus.write_data   = d;
    endtask

    task automatic claim(input logic [4:0] a);
        bus.claim_en   = 1'b1;
        bus.claim_addr = a;
    endtask

    initial begin
        reset_n = 1'b0;
        bus.rs_addr = '0; bus.rt_addr = '0; bus.use_rs = 1'b0; bus.use_rt = 1'b0;
        bus.write_addr = '0; bus.write_data = '0; bus.claim_addr = '0; bus.cmp_mode = 2'b00;
        idle();
        #2;
        chk("init_rd1", bus.read_data_1, 32'h0);
        chk("init_cmp_eq", {31'b0, bus.cmp_true}, 32'h1);
        tick();
        reset_n = 1'b1;
        tick();

        // reset clears data and scoreboard asynchronously
        wr(5'd5, 32'hDEADBEEF); claim(5'd5);
        tick();
        idle();
        bus.rs_addr = 5'd5; bus.use_rs = 1'b1;
        #1;
        chk("pre_rst_rd1", bus.read_data_1, 32'hDEADBEEF);
        chk("pre_rst_stall", {31'b0, bus.stall}, 32'h1);
        reset_n = 1'b0;
        #1;
        chk("rst_rd1", bus.read_data_1, 32'h0);
        chk("rst_rd1_nb", bus_n.read_data_1, 32'h0);
        chk("rst_busy1", {31'b0, bus.busy_1}, 32'h0);
        chk("rst_stall", {31'b0, bus.stall}, 32'h0);
        chk("rst_cmp_eq", {31'b0, bus.cmp_true}, 32'h1);
        bus.cmp_mode = 2'b10;
        #1;
        chk("rst_cmp_ltz", {31'b0, bus.cmp_true}, 32'h0);
        bus.cmp_mode = 2'b00;
        wr(5'd6, 32'h11111111);
        tick();
        idle();
        #2;
        reset_n = 1'b1;
        tick();
        bus.rs_addr = 5'd6;
        #1;
        chk("rst_write_lost", bus.read_data_1, 32'h0);

        // bypass: same-cycle forward only on the bypassing instance
        bus.rs_addr = 5'd7; bus.use_rs = 1'b0;
        wr(5'd7, 32'h12345678);
        #1;
        chk("byp_rd1", bus.read_data_1, 32'h12345678);
        chk("nobyp_rd1_old", bus_n.read_data_1, 32'h0);
        tick();
        idle();
        #1;
        chk("nobyp_rd1_new", bus_n.read_data_1, 32'h12345678);
        bus.rt_addr = 5'd7;
        #1;
        chk("rd2_r7", bus.read_data_2, 32'h12345678);

        // register zero ignores writes and claims
        bus.rs_addr = 5'd0; bus.rt_addr = 5'd0; bus.use_rs = 1'b1;
        wr(5'd0, 32'hFFFFFFFF); claim(5'd0);
        #1;
        chk("zero_byp_rd1", bus.read_data_1, 32'h0);
        tick();
        idle();
        #1;
        chk("zero_rd1", bus.read_data_1, 32'h0);
        chk("zero_busy1", {31'b0, bus.busy_1}, 32'h0);
        chk("zero_stall", {31'b0, bus.stall}, 32'h0);

        // scoreboard: claim r9 in cycle 0, write it in cycle 3
        bus.rs_addr = 5'd9; bus.use_rs = 1'b1;
        claim(5'd9);
        #1;
        chk("sb_c0_stall", {31'b0, bus.stall}, 32'h0);
        tick();
        idle();
        #1;
        chk("sb_c1_stall", {31'b0, bus.stall}, 32'h1);
        chk("sb_c1_busy1", {31'b0, bus.busy_1}, 32'h1);
        tick();
        #1;
        chk("sb_c2_stall", {31'b0, bus.stall}, 32'h1);
        tick();
        wr(5'd9, 32'h55);
        #1;
        chk("sb_c3_stall", {31'b0, bus.stall}, 32'h0);
        chk("sb_c3_rd1", bus.read_data_1, 32'h55);
        chk("sb_c3_nb_stall", {31'b0, bus_n.stall}, 32'h1);
        tick();
        idle();
        #1;
        chk("sb_c4_stall", {31'b0, bus.stall}, 32'h0);
        chk("sb_c4_nb_stall", {31'b0, bus_n.stall}, 32'h0);
        chk("sb_c4_nb_rd1", bus_n.read_data_1, 32'h55);

        // pending but unused operand does not stall; rt port path
        bus.rs_addr = 5'd10; bus.use_rs = 1'b0;
        claim(5'd10);
        tick();
        idle();
        #1;
        chk("unused_busy1", {31'b0, bus.busy_1}, 32'h1);
        chk("unused_stall", {31'b0, bus.stall}, 32'h0);
        bus.rt_addr = 5'd10; bus.use_rt = 1'b1;
        #1;
        chk("rt_busy2", {31'b0, bus.busy_2}, 32'h1);
        chk("rt_stall", {31'b0, bus.stall}, 32'h1);
        wr(5'd10, 32'h0);
        tick();
        idle();
        bus.use_rt = 1'b0;

        // simultaneous write and claim: data lands, pending stays set
        bus.rs_addr = 5'd4;
        wr(5'd4, 32'hA5A5A5A5); claim(5'd4);
        tick();
        idle();
        #1;
        chk("wc_rd1", bus.read_data_1, 32'hA5A5A5A5);
        chk("wc_busy1", {31'b0, bus.busy_1}, 32'h1);
        claim(5'd4);
        tick();
        idle();
        #1;
        chk("reclaim_busy1", {31'b0, bus.busy_1}, 32'h1);
        wr(5'd4, 32'h1);
        tick();
        idle();
        #1;
        chk("clear_busy1", {31'b0, bus.busy_1}, 32'h0);

        // comparator
        wr(5'd1, 32'h80000000);
        tick();
        wr(5'd2, 32'h80000000);
        tick();
        idle();
        bus.rs_addr = 5'd1; bus.rt_addr = 5'd2;
        for (int m = 0; m < 4; m++) begin
            logic [3:0] exp_v;
            exp_v = 4'b0101;
            bus.cmp_mode = 2'(m);
            #1;
            chk($sformatf("cmp_neg_m%0d", m), {31'b0, bus.cmp_true}, {31'b0, exp_v[m]});
        end
        bus.rt_addr = 5'd3;
        bus.cmp_mode = 2'b01;
        #1;
        chk("cmp_ne_diff", {31'b0, bus.cmp_true}, 32'h1);
        bus.cmp_mode = 2'b00;
        #1;
        chk("cmp_eq_diff", {31'b0, bus.cmp_true}, 32'h0);
        bus.rs_addr = 5'd3;
        bus.cmp_mode = 2'b10;
        #1;
        chk("cmp_zero_ltz", {31'b0, bus.cmp_true}, 32'h0);
        bus.cmp_mode = 2'b11;
        #1;
        chk("cmp_zero_gez", {31'b0, bus.cmp_true}, 32'h1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/regfile_scoreboard.md
# regfile_scoreboard

Parametrised general-purpose register file for the pipelined MIPS core, replacing the fixed 32x32 single-mode file used by the decode stage. It adds a same-cycle write-to-read bypass, a per-register pending-write scoreboard for long-latency producers (loads, multiply/divide), a hazard stall output, and a mode-selectable branch comparator on the bypassed operands. It sits in ID, fed by WB writes and by the issue logic's destination claims.

## Interface
- DATA_W, 32, register width in bits.
- ADDR_W, 5, address width; depth = 2**ADDR_W.
- ZERO_REG, 1, when 1 register 0 reads as 0 and ignores writes and claims.
- BYPASS, 1, when 1 a write in the current cycle is forwarded to matching read ports combinationally.

Ports:
- clk  in  1  rising-edge clock.
- reset_n  in  1  asynchronous, active-low reset.
- rs_addr, rt_addr  in  ADDR_W  read addresses.
- use_rs, use_rt  in  1  decode stage actually consumes that operand.
- read_data_1, read_data_2  out  DATA_W  operand data (bypassed when BYPASS=1).
- reg_write_en  in  1  WB write strobe.
- write_addr  in  ADDR_W  WB destination.
- write_data  in  DATA_W  WB data.
- claim_en  in  1  issue of a long-latency op; marks claim_addr pending.
- claim_addr  in  ADDR_W  destination being claimed.
- busy_1, busy_2  out  1  rs/rt register pending and not being written this cycle.
- stall  out  1  (busy_1 & use_rs) | (busy_2 & use_rt).
- cmp_mode  in  2  00 EQ, 01 NE, 10 LTZ (rs<0 signed), 11 GEZ (rs>=0 signed).
- cmp_true  out  1  comparison result on read_data_1/read_data_2.

## Operation
- Storage: 2**ADDR_W x DATA_W flops plus 2**ADDR_W pending bits.
- Write: on posedge, if reg_write_en and not (ZERO_REG and write_addr==0), regs[write_addr] <= write_data; clears pending[write_addr].
- Claim: on posedge, if claim_en and not (ZERO_REG and claim_addr==0), pending[claim_addr] <= 1.
- Same address written and claimed in one cycle: data written, pending ends 1 (claim wins; newer producer owns it).
- Claim of already-pending register: stays 1, no error.
- Read n: if ZERO_REG and addr==0 -> 0; else if BYPASS and reg_write_en and write_addr==addr (and addr nonzero under ZERO_REG) -> write_data; else regs[addr].
- busy_n = pending[addr] and not (reg_write_en and write_addr==addr); forced 0 for reg 0 under ZERO_REG. With BYPASS=0, busy_n = pending[addr] only (no same-cycle forgiveness).
- Comparator purely combinational on read_data outputs; LTZ/GEZ use read_data_1 MSB only.
- stall is combinational; block never holds state on stall.

## Timing
- Reset (reset_n low, async): all regs 0, all pending 0 immediately; outputs: read_data_1/2 = 0, busy_1/2 = 0, stall = 0, cmp_true = 1 if cmp_mode EQ or GEZ else 0.
- Reset released mid-cycle: first update at next posedge with reset_n high; writes/claims asserted during reset are lost.
- Write latency: 0 cycles with BYPASS=1 (same-cycle forward), 1 cycle with BYPASS=0.
- Claim latency: busy visible the cycle after claim_en; claim in cycle N, write in N+k -> busy high N+1..N+k-1 and low in N+k (BYPASS=1).
- Address wrap: none; all ADDR_W values valid.

## Test plan
- Reset: drive reset_n=0 mid-cycle after writing 0xDEADBEEF to r5 -> r5 reads 0 immediately, busy/stall 0, cmp_true=1 with cmp_mode=00.
- Bypass: write r7=0x12345678 while rs_addr=7 same cycle -> read_data_1=0x12345678 that cycle (BYPASS=1), old value that cycle and new next cycle (BYPASS=0).
- Zero register: write r0=0xFFFFFFFF and claim r0 -> r0 reads 0, busy_1=0 with rs_addr=0, stall=0.
- Scoreboard: claim r9 cycle 0, rs_addr=9, use_rs=1, write r9=0x55 cycle 3 -> stall=1 cycles 1-2, stall=0 and read_data_1=0x55 cycle 3; use_rs=0 -> stall=0 throughout.
- Simultaneous write+claim r4 -> r4 data updated, busy on r4 next cycle =1.
- Comparator: rs=0x80000000, rt=0x80000000 -> EQ=1, NE=0, LTZ=1, GEZ=0; rs=0 -> LTZ=0, GEZ=1.
